// File: rtl/charge_accum_ctrl_pkg.sv
// Shared widths, saturation bounds and the issue-stage bundle
// for the charge accumulate controller.
package charge_pkg;

   localparam int ADDR_W   = 8;
   localparam int CHARGE_W = 16;
   localparam int WEIGHT_W = 8;

   localparam logic signed [CHARGE_W-1:0] CHARGE_MAX = 16'sh7FFF;
   localparam logic signed [CHARGE_W-1:0] CHARGE_MIN = 16'sh8000;

   typedef struct packed {
      logic                       valid;
      logic                       clear;
      logic [ADDR_W-1:0]          addr;
      logic signed [WEIGHT_W-1:0] weight;
   } stage_t;

endpackage

// File: rtl/charge_accum_ctrl_if.sv
// Event, fire and charge-RAM signals of the accumulate controller.
// slave = controller side, master = dispatch/RAM/consumer side.
interface charge_accum_ctrl_if;
   import charge_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic                in_clear;
   logic [ADDR_W-1:0]   in_addr;
   logic [WEIGHT_W-1:0] in_weight;
   logic [CHARGE_W-1:0] cfg_threshold;
   logic                fire_valid;
   logic                fire_ready;
   logic [ADDR_W-1:0]   fire_addr;
   logic [ADDR_W-1:0]   ram_rd_addr;
   logic                ram_rd_en;
   logic [CHARGE_W-1:0] ram_rd_data;
   logic [ADDR_W-1:0]   ram_wr_addr;
   logic                ram_wr_en;
   logic [CHARGE_W-1:0] ram_wr_data;
   logic                busy;

   modport slave (
      input  in_valid, in_clear, in_addr, in_weight,
      input  cfg_threshold, fire_ready, ram_rd_data,
      output in_ready, fire_valid, fire_addr,
      output ram_rd_addr, ram_rd_en,
      output ram_wr_addr, ram_wr_en, ram_wr_data,
      output busy
   );

   modport master (
      output in_valid, in_clear, in_addr, in_weight,
      output cfg_threshold, fire_ready, ram_rd_data,
      input  in_ready, fire_valid, fire_addr,
      input  ram_rd_addr, ram_rd_en,
      input  ram_wr_addr, ram_wr_en, ram_wr_data,
      input  busy
   );

endinterface

// File: rtl/charge_accum_ctrl_sat_add.sv
// Signed charge + signed weight adder clamped to the charge range.
module sat_add
   import charge_pkg::*;
(
   input  logic signed [CHARGE_W-1:0] a_i,
   input  logic signed [WEIGHT_W-1:0] b_i,
   output logic signed [CHARGE_W-1:0] sum_o
);

   logic [CHARGE_W:0] wide;

   always_comb begin
      wide = {a_i[CHARGE_W-1], a_i}
           + {{(CHARGE_W+1-WEIGHT_W){b_i[WEIGHT_W-1]}}, b_i};
      // top two bits disagree only on overflow
      case (wide[CHARGE_W -: 2])
         2'b01:   sum_o = CHARGE_MAX;
         2'b10:   sum_o = CHARGE_MIN;
         default: sum_o = wide[CHARGE_W-1:0];
      endcase
   end

endmodule

// File: rtl/charge_accum_ctrl.sv
// Two-stage read-modify-write of neuron charge with saturation,
// threshold fire and a one-entry forward for back-to-back events.
module charge_accum_ctrl
   import charge_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   charge_accum_ctrl_if.slave  bus
);

   stage_t                      s1_q, s1_d;
   logic                        fwd_valid_q, fwd_valid_d;
   logic [ADDR_W-1:0]           fwd_addr_q, fwd_addr_d;
   logic signed [CHARGE_W-1:0]  fwd_data_q, fwd_data_d;
   logic                        fire_valid_q, fire_valid_d;
   logic [ADDR_W-1:0]           fire_addr_q, fire_addr_d;

   logic                        accept;
   logic                        fwd_hit;
   logic                        fire_s2;
   logic signed [CHARGE_W-1:0]  old_chg;
   logic signed [CHARGE_W-1:0]  sum;
   logic signed [CHARGE_W-1:0]  wr_data;

   sat_add u_sat (
      .a_i   (old_chg),
      .b_i   (s1_q.weight),
      .sum_o (sum)
   );

   // RAM is read-before-write, so last cycle's write must bypass it
   always_comb begin
      fwd_hit = fwd_valid_q && (fwd_addr_q == s1_q.addr);
      old_chg = fwd_hit ? fwd_data_q : $signed(bus.ram_rd_data);
      fire_s2 = s1_q.valid && !s1_q.clear
             && (sum >= $signed(bus.cfg_threshold));
      wr_data = (s1_q.clear || fire_s2) ? '0 : sum;
   end

   assign bus.in_ready    = reset && !fire_valid_q && !fire_s2;
   assign accept          = bus.in_valid && bus.in_ready;
   assign bus.ram_rd_en   = accept && !bus.in_clear;
   assign bus.ram_rd_addr = bus.ram_rd_en ? bus.in_addr : '0;
   assign bus.ram_wr_en   = s1_q.valid;
   assign bus.ram_wr_addr = s1_q.valid ? s1_q.addr : '0;
   assign bus.ram_wr_data = s1_q.valid ? wr_data : '0;
   assign bus.fire_valid  = fire_valid_q;
   assign bus.fire_addr   = fire_addr_q;
   assign bus.busy        = s1_q.valid || fire_valid_q;

   always_comb begin
      s1_d         = s1_q;
      s1_d.valid   = accept;
      fwd_valid_d  = s1_q.valid;
      fwd_addr_d   = fwd_addr_q;
      fwd_data_d   = fwd_data_q;
      fire_valid_d = fire_valid_q;
      fire_addr_d  = fire_addr_q;
      if (accept) begin
         s1_d.clear  = bus.in_clear;
         s1_d.addr   = bus.in_addr;
         s1_d.weight = bus.in_weight;
      end
      if (s1_q.valid) begin
         fwd_addr_d = s1_q.addr;
         fwd_data_d = wr_data;
      end
      if (fire_s2) begin
         fire_valid_d = 1'b1;
         fire_addr_d  = s1_q.addr;
      end else if (bus.fire_ready) begin
         fire_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q         <= '0;
         fwd_valid_q  <= 1'b0;
         fwd_addr_q   <= '0;
         fwd_data_q   <= '0;
         fire_valid_q <= 1'b0;
         fire_addr_q  <= '0;
      end else begin
         s1_q         <= s1_d;
         fwd_valid_q  <= fwd_valid_d;
         fwd_addr_q   <= fwd_addr_d;
         fwd_data_q   <= fwd_data_d;
         fire_valid_q <= fire_valid_d;
         fire_addr_q  <= fire_addr_d;
      end
   end

endmodule

// File: tb/tb_charge_accum_ctrl.sv
// Directed bench for charge_accum_ctrl with a read-before-write
// charge RAM model and a backdoor preload port.
module tb_charge_accum_ctrl;
   import charge_pkg::*;

   logic clk = 1'b0;
   logic reset;

   charge_accum_ctrl_if bus();

   charge_accum_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [256];
   logic [15:0] rd_q;
   logic        bd_en;
   logic [7:0]  bd_addr;
   logic [15:0] bd_data;

   always @(posedge clk) begin
      if (bus.ram_rd_en) rd_q <= mem[bus.ram_rd_addr];
      if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
      if (bd_en) mem[bd_addr] <= bd_data;
   end

   assign bus.ram_rd_data = rd_q;

   int checks = 0;
   int passed = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bd_write(input logic [7:0] a, input logic [15:0] d);
      bd_en   = 1'b1;
      bd_addr = a;
      bd_data = d;
      tick();
      bd_en   = 1'b0;
   endtask

   task automatic drive(input logic clr, input logic [7:0] a,
                        input logic [7:0] w);
      bus.in_valid  = 1'b1;
      bus.in_clear  = clr;
      bus.in_addr   = a;
      bus.in_weight = w;
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0)
         $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready);
      else passed++;
      checks++;
      if (bus.busy !== 1'b0 || bus.fire_valid !== 1'b0)
         $display("FAIL rst_busy_fire got=%0b%0b exp=00",
                  bus.busy, bus.fire_valid);
      else passed++;
      checks++;
      if (bus.ram_wr_en !== 1'b0 || bus.ram_rd_en !== 1'b0)
         $display("FAIL rst_ram_en got=%0b%0b exp=00",
                  bus.ram_wr_en, bus.ram_rd_en);
      else passed++;
      reset = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1)
         $display("FAIL rst_release_ready got=%0b exp=1", bus.in_ready);
      else passed++;
      tick();
   endtask

   task automatic test_forward;
      bus.cfg_threshold = 16'd1000;
      bus.fire_ready    = 1'b1;
      bd_write(8'd5, 16'd0);
      drive(1'b0, 8'd5, 8'd10);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.ram_rd_en !== 1'b1 ||
          bus.ram_rd_addr !== 8'd5)
         $display("FAIL fwd_issue got rdy=%0b en=%0b a=%0d exp 1 1 5",
                  bus.in_ready, bus.ram_rd_en, bus.ram_rd_addr);
      else passed++;
      tick();
      bus.in_weight = 8'd20;
      @(negedge clk);
      checks++;
      if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 8'd5 ||
          bus.ram_wr_data !== 16'd10)
         $display("FAIL fwd_wr1 got en=%0b a=%0d d=%0d exp 1 5 10",
                  bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data);
      else passed++;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ram_wr_data !== 16'd30)
         $display("FAIL fwd_wr2 got=%0d exp=30", bus.ram_wr_data);
      else passed++;
      tick();
      @(negedge clk);
      checks++;
      if (bus.fire_valid !== 1'b0)
         $display("FAIL fwd_nofire got=%0b exp=0", bus.fire_valid);
      else passed++;
      tick();
      checks++;
      if (mem[5] !== 16'd30)
         $display("FAIL fwd_ram5 got=%0d exp=30", mem[5]);
      else passed++;
   endtask

   task automatic test_saturate;
      bus.cfg_threshold = 16'h7FFF;
      bus.fire_ready    = 1'b1;
      bd_write(8'd7, 16'd32760);
      drive(1'b0, 8'd7, 8'd100);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_data !== 16'd0)
         $display("FAIL sat_fire_wr got en=%0b d=%h exp 1 0000",
                  bus.ram_wr_en, bus.ram_wr_data);
      else passed++;
      checks++;
      if (bus.in_ready !== 1'b0)
         $display("FAIL sat_s2_block got=%0b exp=0", bus.in_ready);
      else passed++;
      tick();
      @(negedge clk);
      checks++;
      if (bus.fire_valid !== 1'b1 || bus.fire_addr !== 8'd7)
         $display("FAIL sat_fire got v=%0b a=%0d exp 1 7",
                  bus.fire_valid, bus.fire_addr);
      else passed++;
      tick();
      @(negedge clk);
      checks++;
      if (bus.fire_valid !== 1'b0 || mem[7] !== 16'd0)
         $display("FAIL sat_fire_done got v=%0b m=%h exp 0 0000",
                  bus.fire_valid, mem[7]);
      else passed++;
      tick();
      bd_write(8'd7, 16'h8044);
      drive(1'b0, 8'd7, 8'h80);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ram_wr_data !== 16'h8000)
         $display("FAIL sat_neg got=%h exp=8000", bus.ram_wr_data);
      else passed++;
      tick();
      @(negedge clk);
      checks++;
      if (bus.fire_valid !== 1'b0 || mem[7] !== 16'h8000)
         $display("FAIL sat_neg_ram got v=%0b m=%h exp 0 8000",
                  bus.fire_valid, mem[7]);
      else passed++;
      tick();
   endtask

   task automatic test_backpressure;
      bus.cfg_threshold = 16'd50;
      bus.fire_ready    = 1'b0;
      bd_write(8'd3, 16'd40);
      bd_write(8'd4, 16'd0);
      drive(1'b0, 8'd3, 8'd10);
      tick();
      drive(1'b0, 8'd4, 8'd1);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.ram_wr_data !== 16'd0 ||
          bus.ram_wr_addr !== 8'd3)
         $display("FAIL bp_s2 got rdy=%0b d=%0d a=%0d exp 0 0 3",
                  bus.in_ready, bus.ram_wr_data, bus.ram_wr_addr);
      else passed++;
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.fire_valid !== 1'b1 || bus.fire_addr !== 8'd3)
            $display("FAIL bp_hold%0d got v=%0b a=%0d exp 1 3",
                     i, bus.fire_valid, bus.fire_addr);
         else passed++;
         checks++;
         if (bus.in_ready !== 1'b0 || bus.ram_wr_en !== 1'b0)
            $display("FAIL bp_stall%0d got rdy=%0b wr=%0b exp 0 0",
                     i, bus.in_ready, bus.ram_wr_en);
         else passed++;
         tick();
      end
      bus.fire_ready = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (bus.fire_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL bp_release got v=%0b rdy=%0b exp 0 1",
                  bus.fire_valid, bus.in_ready);
      else passed++;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ram_wr_en !== 1'b1 || bus.ram_wr_addr !== 8'd4 ||
          bus.ram_wr_data !== 16'd1)
         $display("FAIL bp_late got en=%0b a=%0d d=%0d exp 1 4 1",
                  bus.ram_wr_en, bus.ram_wr_addr, bus.ram_wr_data);
      else passed++;
      tick();
      tick();
      checks++;
      if (mem[3] !== 16'd0 || mem[4] !== 16'd1)
         $display("FAIL bp_ram got m3=%0d m4=%0d exp 0 1",
                  mem[3], mem[4]);
      else passed++;
   endtask

   task automatic test_clear_forward;
      bus.cfg_threshold = 16'd1000;
      bus.fire_ready    = 1'b1;
      bd_write(8'd9, 16'd123);
      drive(1'b1, 8'd9, 8'd55);
      @(negedge clk);
      checks++;
      if (bus.ram_rd_en !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL clr_noread got en=%0b rdy=%0b exp 0 1",
                  bus.ram_rd_en, bus.in_ready);
      else passed++;
      tick();
      drive(1'b0, 8'd9, 8'hFC);
      @(negedge clk);
      checks++;
      if (bus.ram_wr_data !== 16'd0 || bus.ram_wr_addr !== 8'd9)
         $display("FAIL clr_wr got d=%0d a=%0d exp 0 9",
                  bus.ram_wr_data, bus.ram_wr_addr);
      else passed++;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ram_wr_data !== 16'hFFFC)
         $display("FAIL clr_fwd got=%h exp=fffc", bus.ram_wr_data);
      else passed++;
      tick();
      @(negedge clk);
      checks++;
      if (bus.fire_valid !== 1'b0 || mem[9] !== 16'hFFFC)
         $display("FAIL clr_ram got v=%0b m=%h exp 0 fffc",
                  bus.fire_valid, mem[9]);
      else passed++;
      tick();
   endtask

   task automatic test_interleave;
      bus.cfg_threshold = 16'd1000;
      bd_write(8'd1, 16'd0);
      bd_write(8'd2, 16'd0);
      drive(1'b0, 8'd1, 8'd1);
      tick();
      bus.in_addr = 8'd2;
      @(negedge clk);
      checks++;
      if (bus.ram_wr_addr !== 8'd1 || bus.ram_wr_data !== 16'd1)
         $display("FAIL il_w1 got a=%0d d=%0d exp 1 1",
                  bus.ram_wr_addr, bus.ram_wr_data);
      else passed++;
      tick();
      bus.in_addr = 8'd1;
      @(negedge clk);
      checks++;
      if (bus.ram_wr_addr !== 8'd2 || bus.ram_wr_data !== 16'd1)
         $display("FAIL il_w2 got a=%0d d=%0d exp 2 1",
                  bus.ram_wr_addr, bus.ram_wr_data);
      else passed++;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ram_wr_addr !== 8'd1 || bus.ram_wr_data !== 16'd2)
         $display("FAIL il_w3 got a=%0d d=%0d exp 1 2",
                  bus.ram_wr_addr, bus.ram_wr_data);
      else passed++;
      tick();
      tick();
      checks++;
      if (mem[1] !== 16'd2 || mem[2] !== 16'd1)
         $display("FAIL il_ram got m1=%0d m2=%0d exp 2 1",
                  mem[1], mem[2]);
      else passed++;
   endtask

   task automatic test_reset_drop;
      bus.cfg_threshold = 16'd1;
      bus.fire_ready    = 1'b0;
      bd_write(8'd11, 16'd0);
      drive(1'b0, 8'd11, 8'd5);
      tick();
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ram_wr_en !== 1'b0 || bus.fire_valid !== 1'b0)
         $display("FAIL rd_drop got wr=%0b v=%0b exp 0 0",
                  bus.ram_wr_en, bus.fire_valid);
      else passed++;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL rd_held got rdy=%0b busy=%0b exp 0 0",
                  bus.in_ready, bus.busy);
      else passed++;
      tick();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1)
         $display("FAIL rd_release got=%0b exp=1", bus.in_ready);
      else passed++;
      tick();
      @(negedge clk);
      checks++;
      if (bus.fire_valid !== 1'b0 || mem[11] !== 16'd0)
         $display("FAIL rd_after got v=%0b m=%0d exp 0 0",
                  bus.fire_valid, mem[11]);
      else passed++;
      tick();
   endtask

   initial begin
      reset             = 1'b0;
      bd_en             = 1'b0;
      bd_addr           = '0;
      bd_data           = '0;
      bus.in_valid      = 1'b0;
      bus.in_clear      = 1'b0;
      bus.in_addr       = '0;
      bus.in_weight     = '0;
      bus.cfg_threshold = 16'd1000;
      bus.fire_ready    = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_forward();
      test_saturate();
      test_backpressure();
      test_clear_forward();
      test_interleave();
      test_reset_drop();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
